// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one external ALU among NREQ requesters with registered per-requester result slots.
// Optional ALU_ARB_STATS_EN adds grant_cnt, a saturating per-requester accepted-op counter.
module alu_share_arb #(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int NOPS = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*5-1:0] req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [NREQ*W-1:0] rsp_res,
  output logic [NREQ-1:0]   rsp_zf,
  output logic [NREQ-1:0]   rsp_err,
  output logic [4:0]        alu_I,
  output logic [W-1:0]      alu_op1,
  output logic [W-1:0]      alu_op2,
  input  logic [W-1:0]      alu_res,
  input  logic              alu_zf,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   idx;
  logic            found;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [4:0]      gop;
  logic [W-1:0]    ga;
  logic [W-1:0]    gb;
  logic            illegal;

  // A full slot blocks its requester even if it drains this same cycle.
  assign elig = req_valid & ~rsp_valid;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && elig[idx]) begin
        found       = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  always_comb begin
    gop = '0;
    ga  = '0;
    gb  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gop = req_op[i*5 +: 5];
        ga  = req_a[i*W +: W];
        gb  = req_b[i*W +: W];
      end
    end
  end

  assign illegal   = found && (32'(gop) >= NOPS);
  assign req_ready = grant;
  assign alu_I     = illegal ? 5'd0 : gop;
  assign alu_op1   = ga;
  assign alu_op2   = gb;
  assign busy      = (|req_valid) | (|rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Grant only reaches an empty slot, so fill and drain never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_res   <= '0;
      rsp_zf    <= '0;
      rsp_err   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          rsp_valid[i]     <= 1'b1;
          rsp_res[i*W +: W] <= illegal ? '0 : alu_res;
          rsp_zf[i]        <= illegal ? 1'b1 : alu_zf;
          rsp_err[i]       <= illegal;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed vector bench for alu_share_arb with an attached reference ALU.
module tb_alu_share_arb;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*5-1:0] req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [NREQ*W-1:0] rsp_res;
  logic [NREQ-1:0]   rsp_zf;
  logic [NREQ-1:0]   rsp_err;
  logic [4:0]        alu_I;
  logic [W-1:0]      alu_op1;
  logic [W-1:0]      alu_op2;
  logic [W-1:0]      alu_res;
  logic              alu_zf;
  logic              busy;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.NREQ(NREQ), .W(W), .NOPS(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .rsp_zf(rsp_zf), .rsp_err(rsp_err),
    .alu_I(alu_I), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_zf(alu_zf),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .busy(busy)
  );

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 17 pass operand 1.
  always_comb begin
    case (alu_I)
      5'd0:    alu_res = alu_op1 + alu_op2;
      5'd1:    alu_res = alu_op1 - alu_op2;
      5'd2:    alu_res = alu_op1 & alu_op2;
      5'd3:    alu_res = alu_op1 | alu_op2;
      5'd4:    alu_res = alu_op1 ^ alu_op2;
      5'd17:   alu_res = alu_op1;
      default: alu_res = '0;
    endcase
    alu_zf = (alu_res == '0);
  end

  typedef struct {
    int         r;
    logic [4:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic       zf;
    logic       err;
    logic [4:0] alu;
  } vec_t;

  vec_t v[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    req_valid = '0;
    rsp_ready = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[r]      = 1'b1;
    req_op[5*r +: 5]  = op;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
  endtask

  initial begin
    v[0] = '{0, 5'd0,  32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 5'd0};
    v[1] = '{1, 5'd1,  32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 5'd1};
    v[2] = '{0, 5'd2,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0, 5'd2};
    v[3] = '{1, 5'd3,  32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 5'd3};
    v[4] = '{0, 5'd4,  32'hAAAA5555, 32'hFFFFFFFF, 32'h5555AAAA, 1'b0, 1'b0, 5'd4};
    v[5] = '{1, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 5'd0};
    v[6] = '{0, 5'd20, 32'd3,        32'd4,        32'd0,        1'b1, 1'b1, 5'd0};
    v[7] = '{1, 5'd17, 32'h00001234, 32'd0,        32'h00001234, 1'b0, 1'b0, 5'd17};
    v[8] = '{0, 5'd18, 32'd1,        32'd1,        32'd0,        1'b1, 1'b1, 5'd0};
    v[9] = '{1, 5'd31, 32'd8,        32'd8,        32'd0,        1'b1, 1'b1, 5'd0};

    rst_n = 1'b0;
    idle();
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_res", 64'(rsp_res), 64'd0);
    chk("reset_rsp_zf", 64'(rsp_zf), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_alu_I", 64'(alu_I), 64'd0);
    do_reset();

    // Single-requester vectors
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      idle();
      set_req(v[n].r, v[n].op, v[n].a, v[n].b);
      #1;
      chk($sformatf("v%0d_ready", n), 64'(req_ready), 64'(2'b01 << v[n].r));
      chk($sformatf("v%0d_alu_I", n), 64'(alu_I), 64'(v[n].alu));
      chk($sformatf("v%0d_busy", n), 64'(busy), 64'd1);
      @(negedge clk);
      idle();
      chk($sformatf("v%0d_rsp_valid", n), 64'(rsp_valid), 64'(2'b01 << v[n].r));
      chk($sformatf("v%0d_res", n), 64'(rsp_res[32*v[n].r +: 32]), 64'(v[n].res));
      chk($sformatf("v%0d_zf", n), 64'(rsp_zf[v[n].r]), 64'(v[n].zf));
      chk($sformatf("v%0d_err", n), 64'(rsp_err[v[n].r]), 64'(v[n].err));
      rsp_ready[v[n].r] = 1'b1;
      @(negedge clk);
      idle();
      chk($sformatf("v%0d_drained", n), 64'(rsp_valid), 64'd0);
    end

    // Both requesters continuously valid: grants alternate, slots refill every other cycle
    do_reset();
    @(negedge clk);
    set_req(0, 5'd0, 32'd1, 32'd2);
    set_req(1, 5'd0, 32'd3, 32'd4);
    rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("alt%0d_grant", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("alt%0d_rsp_valid", k), 64'(rsp_valid),
          (k == 0) ? 64'd0 : ((k % 2 == 1) ? 64'd1 : 64'd2));
      @(negedge clk);
    end
    chk("alt_res1", 64'(rsp_res[63:32]), 64'd7);

    // Held response blocks a new op from the same requester
    do_reset();
    @(negedge clk);
    set_req(1, 5'd1, 32'd9, 32'd9);
    #1;
    chk("hold_grant", 64'(req_ready), 64'd2);
    @(negedge clk);
    set_req(1, 5'd0, 32'd1, 32'd2);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold%0d_ready", k), 64'(req_ready), 64'd0);
      chk($sformatf("hold%0d_valid", k), 64'(rsp_valid), 64'd2);
      chk($sformatf("hold%0d_res", k), 64'(rsp_res[63:32]), 64'd0);
      chk($sformatf("hold%0d_zf", k), 64'(rsp_zf), 64'd2);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    #1;
    chk("hold_same_cycle_drain_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    #1;
    chk("hold_regrant", 64'(req_ready), 64'd2);
    chk("hold_emptied", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    idle();
    chk("hold_new_res", 64'(rsp_res[63:32]), 64'd3);
    chk("hold_new_zf", 64'(rsp_zf[1]), 64'd0);

    // Asynchronous reset right after a grant
    do_reset();
    @(negedge clk);
    set_req(0, 5'd0, 32'd5, 32'd7);
    @(negedge clk);
    idle();
    chk("rst_pre_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(rsp_valid), 64'd0);
    chk("rst_async_res", 64'(rsp_res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after%0d_valid", k), 64'(rsp_valid), 64'd0);
    end
    set_req(0, 5'd0, 32'd1, 32'd1);
    set_req(1, 5'd0, 32'd1, 32'd1);
    #1;
    chk("rst_ptr_zero", 64'(req_ready), 64'd1);
    @(negedge clk);
    idle();

`ifdef ALU_ARB_STATS_EN
    // Accepted-op counter for requester 0 only
    do_reset();
    @(negedge clk);
    set_req(0, 5'd0, 32'd1, 32'd1);
    rsp_ready = 2'b11;
    repeat (600) @(negedge clk);
    idle();
    chk("cnt_req0", 64'(grant_cnt[15:0]), 64'd300);
    chk("cnt_req1", 64'(grant_cnt[31:16]), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
